// File: rtl/ap_ctrl_perf_monitor_if.sv
// rtl/ap_ctrl_perf_monitor_if.sv - ap_ctrl handshake and statistics readout bundle
interface ap_ctrl_perf_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] err;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid, busy, err
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid, busy, err
    );
endinterface

// File: rtl/ap_ctrl_perf_monitor.sv
// rtl/ap_ctrl_perf_monitor.sv - per-channel ap_ctrl handshake statistics with saturating counters
module ap_ctrl_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    input  logic                  clear,
    ap_ctrl_perf_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q     [NUM_CH];
    state_e           state_d     [NUM_CH];
    logic [CNT_W-1:0] lat_cnt_q   [NUM_CH];
    logic [CNT_W-1:0] lat_cnt_d   [NUM_CH];
    logic [CNT_W-1:0] txn_cnt_q   [NUM_CH];
    logic [CNT_W-1:0] txn_cnt_d   [NUM_CH];
    logic [CNT_W-1:0] last_lat_q  [NUM_CH];
    logic [CNT_W-1:0] last_lat_d  [NUM_CH];
    logic [CNT_W-1:0] min_lat_q   [NUM_CH];
    logic [CNT_W-1:0] min_lat_d   [NUM_CH];
    logic [CNT_W-1:0] max_lat_q   [NUM_CH];
    logic [CNT_W-1:0] max_lat_d   [NUM_CH];
    logic [CNT_W-1:0] last_int_q  [NUM_CH];
    logic [CNT_W-1:0] last_int_d  [NUM_CH];
    logic [CNT_W-1:0] int_cnt_q   [NUM_CH];
    logic [CNT_W-1:0] int_cnt_d   [NUM_CH];
    logic [CNT_W-1:0] stall_cnt_q [NUM_CH];
    logic [CNT_W-1:0] stall_cnt_d [NUM_CH];
    logic [CNT_W-1:0] ready_cnt_q [NUM_CH];
    logic [CNT_W-1:0] ready_cnt_d [NUM_CH];
    logic             int_valid_q [NUM_CH];
    logic             int_valid_d [NUM_CH];
    logic             err_q       [NUM_CH];
    logic             err_d       [NUM_CH];
    logic             commit      [NUM_CH];
    logic [CNT_W-1:0] commit_lat  [NUM_CH];

    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] sel_val [2**CH_W];
    logic [NUM_CH-1:0] busy_w, err_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]     <= S_IDLE;
                lat_cnt_q[c]   <= '0;
                txn_cnt_q[c]   <= '0;
                last_lat_q[c]  <= '0;
                min_lat_q[c]   <= '1;
                max_lat_q[c]   <= '0;
                last_int_q[c]  <= '0;
                int_cnt_q[c]   <= '0;
                stall_cnt_q[c] <= '0;
                ready_cnt_q[c] <= '0;
                int_valid_q[c] <= 1'b0;
                err_q[c]       <= 1'b0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]     <= state_d[c];
                lat_cnt_q[c]   <= lat_cnt_d[c];
                txn_cnt_q[c]   <= txn_cnt_d[c];
                last_lat_q[c]  <= last_lat_d[c];
                min_lat_q[c]   <= min_lat_d[c];
                max_lat_q[c]   <= max_lat_d[c];
                last_int_q[c]  <= last_int_d[c];
                int_cnt_q[c]   <= int_cnt_d[c];
                stall_cnt_q[c] <= stall_cnt_d[c];
                ready_cnt_q[c] <= ready_cnt_d[c];
                int_valid_q[c] <= int_valid_d[c];
                err_q[c]       <= err_d[c];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // finish gates every per-channel update; readout stays live in the output process
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]     = state_q[c];
            lat_cnt_d[c]   = lat_cnt_q[c];
            txn_cnt_d[c]   = txn_cnt_q[c];
            last_lat_d[c]  = last_lat_q[c];
            min_lat_d[c]   = min_lat_q[c];
            max_lat_d[c]   = max_lat_q[c];
            last_int_d[c]  = last_int_q[c];
            int_cnt_d[c]   = int_cnt_q[c];
            stall_cnt_d[c] = stall_cnt_q[c];
            ready_cnt_d[c] = ready_cnt_q[c];
            int_valid_d[c] = int_valid_q[c];
            err_d[c]       = err_q[c];
            commit[c]      = 1'b0;
            commit_lat[c]  = '0;

            if (!finish) begin
                case (state_q[c])
                    S_IDLE: begin
                        if (mon.ap_start[c] && !mon.ap_done[c]) begin
                            state_d[c]   = S_BUSY;
                            lat_cnt_d[c] = CNT_ONE;
                        end else if (mon.ap_start[c] && mon.ap_done[c]) begin
                            commit[c]     = 1'b1;
                            commit_lat[c] = CNT_ONE;
                            if (!mon.ap_continue[c]) state_d[c] = S_HOLD;
                        end else if (mon.ap_done[c]) begin
                            err_d[c] = 1'b1;
                        end
                    end
                    S_BUSY: begin
                        if (mon.ap_done[c]) begin
                            commit[c]     = 1'b1;
                            commit_lat[c] = sat_inc(lat_cnt_q[c]);
                            state_d[c]    = mon.ap_continue[c] ? S_IDLE : S_HOLD;
                        end else begin
                            lat_cnt_d[c] = sat_inc(lat_cnt_q[c]);
                        end
                    end
                    S_HOLD: begin
                        if (mon.ap_continue[c]) begin
                            state_d[c] = S_IDLE;
                        end else if (!mon.ap_done[c]) begin
                            err_d[c]   = 1'b1;
                            state_d[c] = S_IDLE;
                        end else begin
                            stall_cnt_d[c] = sat_inc(stall_cnt_q[c]);
                        end
                    end
                    default: state_d[c] = S_IDLE;
                endcase

                if (commit[c]) begin
                    txn_cnt_d[c]  = sat_inc(txn_cnt_q[c]);
                    last_lat_d[c] = commit_lat[c];
                    if (commit_lat[c] < min_lat_q[c]) min_lat_d[c] = commit_lat[c];
                    if (commit_lat[c] > max_lat_q[c]) max_lat_d[c] = commit_lat[c];
                end

                if (mon.ap_ready[c]) begin
                    if (int_valid_q[c]) last_int_d[c] = int_cnt_q[c];
                    int_cnt_d[c]   = CNT_ONE;
                    int_valid_d[c] = 1'b1;
                    ready_cnt_d[c] = sat_inc(ready_cnt_q[c]);
                end else if (int_valid_q[c]) begin
                    int_cnt_d[c] = sat_inc(int_cnt_q[c]);
                end
            end
        end
    end

    // unused channel slots in the select table stay zero so out-of-range reads return 0
    always_comb begin
        for (int c = 0; c < 2**CH_W; c++) sel_val[c] = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_w[c] = (state_q[c] == S_BUSY) || (state_q[c] == S_HOLD);
            err_w[c]  = err_q[c];
            case (mon.rd_sel)
                3'd0:    sel_val[c] = txn_cnt_q[c];
                3'd1:    sel_val[c] = last_lat_q[c];
                3'd2:    sel_val[c] = min_lat_q[c];
                3'd3:    sel_val[c] = max_lat_q[c];
                3'd4:    sel_val[c] = last_int_q[c];
                3'd5:    sel_val[c] = stall_cnt_q[c];
                3'd6:    sel_val[c] = ready_cnt_q[c];
                default: sel_val[c] = CNT_W'({int_valid_q[c], err_q[c], state_q[c]});
            endcase
        end
        rd_valid_d = mon.rd_en;
        rd_data_d  = mon.rd_en ? sel_val[mon.rd_ch] : rd_data_q;
    end

    assign mon.rd_data  = rd_data_q;
    assign mon.rd_valid = rd_valid_q;
    assign mon.busy     = busy_w;
    assign mon.err      = err_w;
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb/tb_ap_ctrl_perf_monitor.sv - directed self-checking bench for ap_ctrl_perf_monitor
module tb_ap_ctrl_perf_monitor;
    logic clock;
    logic reset;
    logic finish0, clear0, finish1, clear1;
    int   tests_run;
    int   tests_failed;
    logic [31:0] d;

    ap_ctrl_perf_monitor_if #(.NUM_CH(4), .CNT_W(32), .CH_W(3)) if0 ();
    ap_ctrl_perf_monitor_if #(.NUM_CH(1), .CNT_W(4),  .CH_W(1)) if1 ();

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .CH_W(3)) u_dut0 (
        .clock  (clock),
        .reset  (reset),
        .finish (finish0),
        .clear  (clear0),
        .mon    (if0.slave)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(4), .CH_W(1)) u_dut1 (
        .clock  (clock),
        .reset  (reset),
        .finish (finish1),
        .clear  (clear1),
        .mon    (if1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd0(input int ch, input int sel, output logic [31:0] data);
        if0.rd_en  = 1'b1;
        if0.rd_ch  = 3'(ch);
        if0.rd_sel = 3'(sel);
        tick();
        check_eq("rd_valid0", 32'(if0.rd_valid), 32'd1);
        data = if0.rd_data;
        if0.rd_en = 1'b0;
    endtask

    task automatic stat0(input string tag, input int ch, input int sel, input logic [31:0] exp);
        logic [31:0] v;
        rd0(ch, sel, v);
        check_eq(tag, v, exp);
    endtask

    task automatic stat1(input string tag, input int sel, input logic [31:0] exp);
        if1.rd_en  = 1'b1;
        if1.rd_ch  = 1'b0;
        if1.rd_sel = 3'(sel);
        tick();
        check_eq("rd_valid1", 32'(if1.rd_valid), 32'd1);
        check_eq(tag, 32'(if1.rd_data), exp);
        if1.rd_en = 1'b0;
    endtask

    // start at edge 0, done at edge lat-1, continue high: latency == lat (lat >= 2)
    task automatic txn0(input int ch, input int lat);
        if0.ap_start[ch] = 1'b1;
        tick();
        if0.ap_start[ch] = 1'b0;
        repeat (lat - 2) tick();
        if0.ap_done[ch] = 1'b1;
        tick();
        if0.ap_done[ch] = 1'b0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        finish0 = 1'b0; clear0 = 1'b0;
        finish1 = 1'b0; clear1 = 1'b0;
        if0.ap_start = '0; if0.ap_ready = '0; if0.ap_done = '0; if0.ap_continue = '1;
        if0.rd_en = 1'b0; if0.rd_ch = '0; if0.rd_sel = '0;
        if1.ap_start = '0; if1.ap_ready = '0; if1.ap_done = '0; if1.ap_continue = '1;
        if1.rd_en = 1'b0; if1.rd_ch = '0; if1.rd_sel = '0;
        repeat (2) tick();
        reset = 1'b0;

        check_eq("rst_busy", 32'(if0.busy), 32'd0);
        check_eq("rst_err", 32'(if0.err), 32'd0);
        check_eq("rst_rd_valid", 32'(if0.rd_valid), 32'd0);
        check_eq("rst_rd_data", if0.rd_data, 32'd0);
        stat0("rst_min_lat", 0, 2, 32'hFFFF_FFFF);
        stat1("rst_min_lat_w4", 2, 32'd15);

        // reset in the middle of a transaction: no commit
        if0.ap_start[0] = 1'b1;
        tick();
        if0.ap_start[0] = 1'b0;
        repeat (2) tick();
        check_eq("busy_before_rst", 32'(if0.busy[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("busy_after_rst", 32'(if0.busy[0]), 32'd0);
        stat0("state_after_rst", 0, 7, 32'd0);
        stat0("txn_after_rst", 0, 0, 32'd0);

        // ch0: start at cycle 0, done at cycle 9
        if0.ap_start[0] = 1'b1;
        tick();
        if0.ap_start[0] = 1'b0;
        check_eq("ch0_busy_c1", 32'(if0.busy[0]), 32'd1);
        repeat (8) tick();
        check_eq("ch0_busy_c9", 32'(if0.busy[0]), 32'd1);
        if0.ap_done[0] = 1'b1;
        tick();
        if0.ap_done[0] = 1'b0;
        check_eq("ch0_busy_c10", 32'(if0.busy[0]), 32'd0);
        stat0("ch0_txn", 0, 0, 32'd1);
        stat0("ch0_last_lat", 0, 1, 32'd10);
        stat0("ch0_min_lat", 0, 2, 32'd10);
        stat0("ch0_max_lat", 0, 3, 32'd10);

        // ch1: latencies 3, 7, 5 then ready at cycles 0, 4, 12
        txn0(1, 3);
        txn0(1, 7);
        txn0(1, 5);
        for (int i = 0; i <= 12; i++) begin
            if0.ap_ready[1] = (i == 0 || i == 4 || i == 12);
            tick();
        end
        if0.ap_ready[1] = 1'b0;
        stat0("ch1_last_lat", 1, 1, 32'd5);
        stat0("ch1_min_lat", 1, 2, 32'd3);
        stat0("ch1_max_lat", 1, 3, 32'd7);
        stat0("ch1_last_int", 1, 4, 32'd8);
        stat0("ch1_ready_cnt", 1, 6, 32'd3);
        stat0("ch1_status", 1, 7, 32'd8);
        stat0("ch1_txn", 1, 0, 32'd3);
        tick();
        check_eq("rd_valid_drop", 32'(if0.rd_valid), 32'd0);
        check_eq("rd_data_hold", if0.rd_data, 32'd3);
        stat0("rd_out_of_range", 5, 0, 32'd0);

        // ch2: done at cycle 5, continue low for four HOLD cycles
        if0.ap_continue[2] = 1'b0;
        if0.ap_start[2] = 1'b1;
        tick();
        if0.ap_start[2] = 1'b0;
        repeat (4) tick();
        if0.ap_done[2] = 1'b1;
        tick();
        repeat (3) tick();
        stat0("ch2_state_hold", 2, 7, 32'd2);
        if0.ap_continue[2] = 1'b1;
        if0.ap_start[2] = 1'b1;
        tick();
        check_eq("ch2_no_start_in_cont", 32'(if0.busy[2]), 32'd0);
        if0.ap_done[2] = 1'b0;
        tick();
        check_eq("ch2_start_next", 32'(if0.busy[2]), 32'd1);
        if0.ap_start[2] = 1'b0;
        if0.ap_done[2] = 1'b1;
        tick();
        if0.ap_done[2] = 1'b0;
        stat0("ch2_stall", 2, 5, 32'd4);
        stat0("ch2_txn", 2, 0, 32'd2);
        stat0("ch2_last_lat", 2, 1, 32'd2);
        stat0("ch2_min_lat", 2, 2, 32'd2);
        stat0("ch2_max_lat", 2, 3, 32'd6);
        stat0("ch2_status", 2, 7, 32'd0);

        // ch3: same-cycle completion, then a stray done
        if0.ap_start[3] = 1'b1;
        if0.ap_done[3] = 1'b1;
        tick();
        if0.ap_start[3] = 1'b0;
        if0.ap_done[3] = 1'b0;
        check_eq("ch3_err_clean", 32'(if0.err), 32'd0);
        stat0("ch3_last_lat", 3, 1, 32'd1);
        stat0("ch3_txn", 3, 0, 32'd1);
        if0.ap_done[3] = 1'b1;
        tick();
        if0.ap_done[3] = 1'b0;
        check_eq("ch3_err_set", 32'(if0.err), 32'h8);
        repeat (3) tick();
        check_eq("ch3_err_sticky", 32'(if0.err), 32'h8);
        stat0("ch3_status", 3, 7, 32'd4);

        // narrow counters: latency saturates
        if1.ap_start[0] = 1'b1;
        tick();
        if1.ap_start[0] = 1'b0;
        repeat (18) tick();
        if1.ap_done[0] = 1'b1;
        tick();
        if1.ap_done[0] = 1'b0;
        stat1("w4_last_lat_sat", 1, 32'd15);
        stat1("w4_txn", 0, 32'd1);

        // finish freezes lat_cnt and ready tracking mid-transaction
        if1.ap_start[0] = 1'b1;
        tick();
        if1.ap_start[0] = 1'b0;
        repeat (2) tick();
        finish1 = 1'b1;
        if1.ap_ready[0] = 1'b1;
        repeat (4) tick();
        stat1("w4_frozen_state", 7, 32'd1);
        check_eq("w4_frozen_busy", 32'(if1.busy), 32'd1);
        if1.ap_ready[0] = 1'b0;
        finish1 = 1'b0;
        if1.ap_done[0] = 1'b1;
        tick();
        if1.ap_done[0] = 1'b0;
        stat1("w4_last_lat_frozen", 1, 32'd4);
        stat1("w4_min_lat", 2, 32'd4);
        stat1("w4_max_lat", 3, 32'd15);
        stat1("w4_ready_frozen", 6, 32'd0);

        // clear wins over finish
        finish1 = 1'b1;
        clear1  = 1'b1;
        tick();
        clear1  = 1'b0;
        finish1 = 1'b0;
        stat1("w4_clr_txn", 0, 32'd0);
        stat1("w4_clr_min", 2, 32'd15);
        stat1("w4_clr_max", 3, 32'd0);
        stat1("w4_clr_last", 1, 32'd0);

        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        check_eq("clr_err", 32'(if0.err), 32'd0);
        check_eq("clr_rd_data", if0.rd_data, 32'd0);
        stat0("clr_ch1_txn", 1, 0, 32'd0);
        stat0("clr_ch0_min", 0, 2, 32'hFFFF_FFFF);
        rd0(2, 5, d);
        check_eq("clr_ch2_stall", d, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
- Parametrised successor to the per-module ap_ctrl status monitors in the cosim dataflow monitor.
- Watches NUM_CH independent ap_start/ap_ready/ap_done/ap_continue handshakes and accumulates per-channel statistics in hardware: transaction count, start-to-done latency (last/min/max), ready-to-ready interval, ready count, and done-held-by-continue stall cycles.
- Adds behaviour the CSV monitors lack: protocol-error detection, saturation, freeze-on-finish, and a register readout port.
- Sits beside the DUT in the cosim top. The bench or a dump task reads the statistics back.

Parameters:
- NUM_CH, 4, number of monitored handshake channels (1..16)
- CNT_W, 32, width of every statistic counter
- CH_W, 2, width of rd_ch; must satisfy 2**CH_W >= NUM_CH

Ports:
- clock  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- finish  in  1  freeze: while 1, no counter or state updates except reset/clear
- clear  in  1  synchronous statistics clear; same effect as reset on all per-channel state
- ap_start  in  NUM_CH  per-channel ap_start
- ap_ready  in  NUM_CH  per-channel ap_ready
- ap_done  in  NUM_CH  per-channel ap_done
- ap_continue  in  NUM_CH  per-channel ap_continue; tie to 1 for ap_ctrl_hs blocks
- rd_en  in  1  readout request
- rd_ch  in  CH_W  channel to read
- rd_sel  in  3  statistic select
- rd_data  out  CNT_W  readout data
- rd_valid  out  1  readout data valid
- busy  out  NUM_CH  channel is in BUSY or HOLD
- err  out  NUM_CH  sticky protocol-error flag per channel

Behaviour:
- Reset/clear values, all channels:
  - state = IDLE; busy = 0; err = 0; rd_valid = 0; rd_data = 0
  - all counters = 0, except min_lat = all-ones
  - int_valid = 0
- reset and clear take priority over finish.
- Per-channel FSM:
  - IDLE:
    - ap_start=1 and ap_done=0: go to BUSY; lat_cnt = 1.
    - ap_start=1 and ap_done=1 (same-cycle completion): latency = 1; commit (see below); go to HOLD if ap_continue=0, else stay IDLE.
    - ap_done=1 and ap_start=0: set err; stay IDLE.
  - BUSY:
    - each cycle without ap_done: lat_cnt += 1.
    - ap_done=1: commit with latency = lat_cnt+1; go to IDLE if ap_continue=1, else go to HOLD.
  - HOLD:
    - ap_done must stay 1; if it drops while ap_continue=0, set err and go to IDLE.
    - ap_continue=0: stall_cnt += 1.
    - ap_continue=1: go to IDLE. No new start is accepted in that cycle; the next start is taken in IDLE the following cycle.
- Commit (same edge as the done transition):
  - txn_cnt += 1
  - last_lat = latency
  - min_lat = min(min_lat, latency)
  - max_lat = max(max_lat, latency)
- Interval tracking, independent of the FSM:
  - ready_cnt += 1 on every cycle with ap_ready=1.
  - int_cnt counts cycles since the last ap_ready.
  - On ap_ready: if int_valid then last_int = int_cnt; then int_cnt = 1 and int_valid = 1.
  - Back-to-back ready gives last_int = 1.
- All counters saturate at 2**CNT_W-1 and never wrap. Once lat_cnt saturates, the latency it commits is the saturated value.
- finish=1: FSM and counters hold their values; readout remains functional.
- Readout:
  - Registered; 1-cycle latency. rd_en sampled at edge N gives rd_valid=1 and rd_data at edge N+1; otherwise rd_valid=0 and rd_data holds its value.
  - rd_ch >= NUM_CH returns 0.
  - Readout reflects the register values before any same-edge update.
- rd_sel encoding:
  - 0 txn_cnt
  - 1 last_lat
  - 2 min_lat
  - 3 max_lat
  - 4 last_int
  - 5 stall_cnt
  - 6 ready_cnt
  - 7 {zero-pad, int_valid, err, state[1:0]}, with IDLE=0, BUSY=1, HOLD=2
- Channels are fully independent; simultaneous events on different channels all update in the same cycle.
- Reset asserted mid-transaction returns the channel to IDLE with no commit.

Test Plan:
- ch0: start pulse at cycle 0, done at cycle 9, continue=1 -> txn_cnt=1, last/min/max_lat=10, busy high for cycles 1..9 and low at cycle 10.
- ch1: three transactions of latency 3, 7, 5 -> txn_cnt=3, last_lat=5, min_lat=3, max_lat=7. ap_ready at cycles 0, 4, 12 -> ready_cnt=3, last_int=8.
- ch2: done at cycle 5 with continue=0 for 4 cycles -> stall_cnt=4, state HOLD during the stall, IDLE after continue; start asserted in the continue cycle is not taken until the next cycle.
- ch3: start and done in the same cycle -> latency=1. Later, ap_done with ap_start=0 in IDLE -> err[3]=1, and it stays 1 until clear.
- CNT_W=4: transaction lasting 20 cycles -> last_lat=15 (saturated). finish=1 mid-transaction holds lat_cnt. clear -> all zeros, min_lat=15.
- Readout: rd_en with rd_ch=5, NUM_CH=4 -> rd_data=0, rd_valid=1 one cycle later. Reset during BUSY -> state 0, txn_cnt unchanged at 0.
